// File: rtl/digital_input_sampler_if.sv
// Bus between the input sampler and the processor port: external lines,
// sampling controls and the FWFT FIFO head.
interface digital_input_sampler_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16,
  parameter int DEPTH = 16
);
  logic [WIDTH-1:0]         din;
  logic                     enable;
  logic [DIV_W-1:0]         divider;
  logic                     change_only;
  logic                     rd_ack;
  logic                     overflow_clr;
  logic [WIDTH-1:0]         dout;
  logic                     dout_valid;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;

  modport master (
    output din, enable, divider, change_only, rd_ack, overflow_clr,
    input  dout, dout_valid, level, overflow
  );
  modport slave (
    input  din, enable, divider, change_only, rd_ack, overflow_clr,
    output dout, dout_valid, level, overflow
  );
endinterface

// File: rtl/digital_input_sampler.sv
// Synchronises async input lines, samples them at a programmable rate
// (optionally only on change) and buffers samples in a FWFT FIFO.
module digital_input_sampler #(
  parameter int WIDTH       = 8,
  parameter int DIV_W       = 16,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk_clk,
  input logic                 reset_reset,
  digital_input_sampler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;
  logic [WIDTH-1:0]                  sync_q;
  logic [DIV_W-1:0]                  cnt;
  logic                              tick;
  logic                              first_pending;
  logic [WIDTH-1:0]                  last_stored;
  logic                              store;
  logic [WIDTH-1:0]                  mem [DEPTH];
  logic [AW:0]                       wr_ptr, rd_ptr;
  logic                              empty, full, push, pop;
  logic                              overflow_q;

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) sync_pipe <= '0;
    else             sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.din};

  assign sync_q = sync_pipe[SYNC_STAGES-1];

  // Counter runs freely through 2^DIV_W if the divider is lowered below it.
  assign tick = bus.enable && (cnt == bus.divider);

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset)      cnt <= '0;
    else if (!bus.enable) cnt <= '0;
    else if (tick)        cnt <= '0;
    else                  cnt <= cnt + 1'b1;

  assign store = tick && (!bus.change_only || first_pending || (sync_q != last_stored));

  // A dropped sample still counts as stored for change detection.
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      first_pending <= 1'b1;
      last_stored   <= '0;
    end else begin
      if (!bus.enable) first_pending <= 1'b1;
      else if (store)  first_pending <= 1'b0;
      if (store) last_stored <= sync_q;
    end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = bus.rd_ack && !empty;
  assign push  = store && (!full || pop);

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= sync_q;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end

  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset)                  overflow_q <= 1'b0;
    else if (store && full && !pop)   overflow_q <= 1'b1;
    else if (bus.overflow_clr)        overflow_q <= 1'b0;

  assign bus.dout       = mem[rd_ptr[AW-1:0]];
  assign bus.dout_valid = !empty;
  assign bus.level      = wr_ptr - rd_ptr;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_digital_input_sampler.sv
// Directed bench for digital_input_sampler: rate, change-only, FIFO full/empty,
// sticky overflow and asynchronous reset behaviour.
module tb_digital_input_sampler;
  localparam int WIDTH = 8, DIV_W = 16, DEPTH = 16;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 gclk = ~gclk;

  digital_input_sampler_if #(.WIDTH(WIDTH), .DIV_W(DIV_W), .DEPTH(DEPTH)) bus ();

  digital_input_sampler #(.WIDTH(WIDTH), .DIV_W(DIV_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_clk     (gclk),
    .reset_reset (rst),
    .bus         (bus.slave)
  );

  typedef struct {
    logic [7:0] din;
    int         hold;
    int         exp_level;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] exp_q [3];

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_level(input int target, input int maxc, output int cyc);
    cyc = 0;
    while (int'(bus.level) != target && cyc < maxc) begin
      step();
      cyc++;
    end
  endtask

  task automatic pop_one();
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h00, 3, 1};
    vecs[1] = '{8'h00, 3, 1};
    vecs[2] = '{8'h01, 3, 2};
    vecs[3] = '{8'h01, 3, 2};
    vecs[4] = '{8'h80, 3, 3};
    exp_q[0] = 8'h00; exp_q[1] = 8'h01; exp_q[2] = 8'h80;

    bus.din = 8'hA5; bus.enable = 1'b0; bus.divider = 16'd3;
    bus.change_only = 1'b0; bus.rd_ack = 1'b0; bus.overflow_clr = 1'b0;
    #22 rst = 1'b0;
    step();

    // reset state
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_level", bus.level, 0);
    chk("rst_ovf", bus.overflow, 1'b0);

    // divider=3: one store every 4 cycles, fill to full, then overflow
    bus.enable = 1'b1;
    wait_level(1, 10, n);
    chk("first_store_lat", n, 4);
    chk("first_dout", bus.dout, 8'hA5);
    chk("first_valid", bus.dout_valid, 1'b1);
    wait_level(2, 10, n);
    chk("store_period", n, 4);
    wait_level(16, 100, n);
    chk("fill_level", bus.level, 16);
    chk("fill_cycles", n, 56);
    chk("fill_ovf", bus.overflow, 1'b0);
    repeat (3) step();
    chk("pre_drop_ovf", bus.overflow, 1'b0);
    step();
    chk("drop_ovf", bus.overflow, 1'b1);
    chk("drop_level", bus.level, 16);

    // clear during a drop loses to set; clear in a quiet cycle works
    bus.divider = 16'd0; bus.overflow_clr = 1'b1;
    step();
    chk("clr_vs_set", bus.overflow, 1'b1);
    bus.enable = 1'b0;
    step();
    chk("clr_quiet", bus.overflow, 1'b0);
    bus.overflow_clr = 1'b0;

    // full FIFO: pop and push on the same edge
    bus.din = 8'h5A;
    repeat (3) step();
    bus.enable = 1'b1; bus.rd_ack = 1'b1;
    step();
    bus.enable = 1'b0; bus.rd_ack = 1'b0;
    chk("fullrw_level", bus.level, 16);
    chk("fullrw_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 15; i++) begin
      chk("drain_old", bus.dout, 8'hA5);
      pop_one();
    end
    chk("drain_new", bus.dout, 8'h5A);
    chk("drain_new_level", bus.level, 1);
    pop_one();
    chk("empty_level", bus.level, 0);

    // rd_ack on empty is ignored
    pop_one();
    chk("uflow_level", bus.level, 0);
    chk("uflow_valid", bus.dout_valid, 1'b0);
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    chk("after_uflow_level", bus.level, 1);
    chk("after_uflow_dout", bus.dout, 8'h5A);
    pop_one();

    // change_only: only the distinct values land in the FIFO
    bus.change_only = 1'b1; bus.din = 8'h00;
    repeat (3) step();
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = vecs[i].din;
      repeat (vecs[i].hold) step();
      chk($sformatf("chg_level_%0d", i), bus.level, vecs[i].exp_level);
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("chg_dout_%0d", i), bus.dout, exp_q[i]);
      pop_one();
    end
    chk("chg_empty", bus.dout_valid, 1'b0);

    // asynchronous reset mid-burst
    bus.change_only = 1'b0; bus.din = 8'hA5; bus.enable = 1'b1;
    wait_level(7, 20, n);
    chk("burst_level", bus.level, 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.dout_valid, 1'b0);
    chk("arst_level", bus.level, 0);
    chk("arst_ovf", bus.overflow, 1'b0);
    bus.din = 8'h3C; bus.change_only = 1'b1; bus.divider = 16'd3;
    #2 rst = 1'b0;
    wait_level(1, 10, n);
    chk("post_rst_lat", n, 4);
    chk("post_rst_dout", bus.dout, 8'h3C);
    chk("post_rst_level", bus.level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digital_input_sampler.md
# digital_input_sampler

Front-end acquisition stage directly upstream of the processor's 8-bit input port. It synchronises the asynchronous external data lines and samples them at a programmable rate, optionally storing only changed values. Samples are buffered in a first-word-fall-through FIFO whose head drives the processor's input data port, so bursts of input activity survive while software is busy with SD-card writes.

## Interface
Parameters:
- WIDTH, 8, sample width in bits (matches processor input port)
- DIV_W, 16, width of sample-rate divider
- DEPTH, 16, FIFO depth in entries; power of two, at least 2
- SYNC_STAGES, 2, synchroniser flops per input bit; at least 2

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- din  in  WIDTH  external data lines, asynchronous to clk_clk
- enable  in  1  sampling enable
- divider  in  DIV_W  sample period minus 1, in clock cycles
- change_only  in  1  1 = store a sample only if it differs from the last stored value
- rd_ack  in  1  pop FIFO head; single-cycle pulse per word
- overflow_clr  in  1  clears overflow
- dout  out  WIDTH  FIFO head; drives processor input_data_export
- dout_valid  out  1  FIFO not empty
- level  out  log2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky flag: a sample was dropped because FIFO was full

## Operation
- Synchroniser: SYNC_STAGES-deep flop chain per bit; sync_q is the last stage. No filtering.
- Rate counter cnt (DIV_W bits):
  - held at 0 while enable=0
  - while enable=1: tick = (cnt == divider); cnt wraps to 0 on tick, otherwise increments
  - divider=0 ticks every cycle
  - divider changes take effect immediately; if cnt > new divider, cnt counts up and wraps through 2^DIV_W
- Store decision on tick:
  - change_only=0: always store
  - change_only=1: store if first_pending=1 or sync_q != last_stored
  - first_pending is set by reset and while enable=0, cleared by the first store
  - last_stored updates only on an actual store
- FIFO: DEPTH entries with separate read and write pointers, each one bit wider than the address. dout = mem[rd_ptr] combinationally; dout_valid = !empty.
- Push and pop rules:
  - Pop when rd_ack=1 and not empty. rd_ack while empty is ignored; level never underflows.
  - Push when store=1 and (not full, or pop in same cycle). Full plus simultaneous pop and push: both occur, level stays DEPTH, no overflow.
  - Store while full with no pop: sample dropped, overflow set, last_stored still updates.
- Overflow: sticky. If set and clear occur in the same cycle, set wins.
- Dropping enable: counter and first_pending re-arm. FIFO contents and overflow are retained.

## Timing
- Reset state: dout=0 (memory cleared), dout_valid=0, level=0, overflow=0, cnt=0, synchroniser=0, last_stored=0, first_pending=1.
- din to sync_q: SYNC_STAGES cycles.
- Store happens on the clock edge where tick=1. dout, dout_valid and level reflect it immediately after that edge, giving zero extra latency into an empty FIFO.
- rd_ack is sampled on the edge. The next head and the decremented level are visible after that edge.
- Enable rising at edge E: first tick is in cycle E+divider, with the store at the end of that cycle. Subsequent ticks every divider+1 cycles.
- Throughput: one store and one pop per cycle maximum.
- Reset asserted mid-operation clears everything asynchronously. Operation resumes on the first edge after release.

## Test plan
- Reset, divider=3, change_only=0, enable=1, din=0xA5 held -> stores every 4 cycles; after first store dout=0xA5, dout_valid=1, level=1; no rd_ack, 16 stores -> level=16, 17th store -> overflow=1, level stays 16.
- divider=0, change_only=1, din steps 0x00,0x00,0x01,0x01,0x80 (each held 3 cycles) -> FIFO holds exactly 0x00,0x01,0x80, read out in order via rd_ack.
- FIFO full, rd_ack pulsed in a tick cycle -> level remains 16, overflow stays 0, oldest word removed, newest appended.
- overflow=1, overflow_clr pulsed during a drop -> overflow stays 1; overflow_clr in a quiet cycle -> overflow=0.
- rd_ack on empty FIFO -> level=0, dout_valid=0, no pointer movement; then a store -> level=1.
- Assert reset_reset asynchronously mid-burst (level=7) -> dout_valid=0, level=0, overflow=0 before next edge; din=0x3C with change_only=1 after release -> first tick stores 0x3C.
